mem_stage_module: RTL and testbench
===================================

Name: mem_stage_module

Overview:
Memory-access stage of the 5-stage ARM pipeline, directly downstream of the execute stage register. It consumes wb_en/mem_r_en/mem_w_en/alu_res/val_r_m/dest and performs LDR/STR through a request/acknowledge handshake to a multi-cycle data memory. While an access is outstanding it freezes the upstream pipeline. Its stage register feeds the write-back stage.

Parameters:
DATA_W, 32, register/data width
REG_ADDR_W, 4, register-file address width
MEM_BASE, 1024, byte address of data word 0
MEM_WORDS, 64, data memory depth in words
MEM_ADDR_W, 6, word address width (log2 MEM_WORDS)
TIMEOUT, 15, max cycles waiting for mem_ack before abort

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
wb_en_in  in  1  write-back enable from execute stage register
mem_r_en_in  in  1  load
mem_w_en_in  in  1  store
alu_res_in  in  DATA_W  byte address / ALU result
val_r_m_in  in  DATA_W  store data
dest_in  in  REG_ADDR_W  destination register
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  MEM_ADDR_W  word address
mem_wdata  out  DATA_W  store data
mem_ack  in  1  single-cycle completion pulse
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
freeze  out  1  stall all upstream stage registers and PC
addr_err  out  1  sticky: out-of-range address or timeout
wb_en_out  out  1  to write-back
mem_r_en_out  out  1  to write-back (selects mem_data_out)
alu_res_out  out  DATA_W  to write-back
mem_data_out  out  DATA_W  to write-back
dest_out  out  REG_ADDR_W  to write-back

Behaviour:
- access = mem_r_en_in | mem_w_en_in; both set means store (write wins).
- Word address = (alu_res_in - MEM_BASE) >> 2, low MEM_ADDR_W bits. In range iff MEM_BASE <= alu_res_in < MEM_BASE + 4*MEM_WORDS. Byte offset bits [1:0] are ignored.
- FSM states: IDLE, WAIT, DONE.
  - IDLE:
    - If access and in range: go to WAIT, freeze=1, mem_req=0.
    - If access and out of range: no request, addr_err set, freeze=0. The instruction passes with mem_data_out=0.
    - If no access: freeze=0 and the instruction passes through.
  - WAIT:
    - mem_req=1 and freeze=1. mem_we/mem_addr/mem_wdata are held stable; inputs are stable because upstream is frozen.
    - A 4-bit counter increments each cycle.
    - On mem_ack: latch mem_rdata into rdata_q and go to DONE.
    - If the counter reaches TIMEOUT without ack: drop mem_req, set addr_err, rdata_q=0, go to DONE.
  - DONE: freeze=0 and mem_req=0. The stage register captures rdata_q. Next state is IDLE. The counter clears.
- Minimum memory-instruction latency is 3 cycles (IDLE, WAIT with immediate ack, DONE). A non-memory instruction takes 1 cycle.
- Because freeze drops in DONE, the next instruction is first seen in IDLE. No access is ever issued twice.
- mem_ack outside WAIT is ignored.
- Stage register (mem_stage_reg), on posedge clk:
  - freeze=1: loads a bubble (wb_en_out=0, mem_r_en_out=0; other fields hold).
  - freeze=0: loads wb_en_in, mem_r_en_in, alu_res_in, dest_in, and mem_data_out. mem_data_out = rdata_q in DONE, else 0.
- Reset (rst=0, at any time including mid-WAIT):
  - State goes to IDLE; counter, rdata_q and addr_err clear.
  - mem_req=0 immediately, freeze=0.
  - All stage-register outputs are 0.
  - A late mem_ack after reset is ignored.
- addr_err clears only on reset.

Decomposition:
- Shared constants package holds the width macros (DATA_W, REG_ADDR_W), MEM_BASE, MEM_WORDS and the FSM state encoding (2-bit).
- Sub-module mem_stage_reg holds the MEM/WB pipeline register with the bubble-on-freeze rule.
- FSM, address decode and timeout counter sit in mem_stage_module.

Test Plan:
- Load, alu_res_in=1028, mem_ack on the 1st WAIT cycle with rdata=0xDEADBEEF -> mem_addr=1, mem_we=0, freeze high 2 cycles; next edge gives mem_data_out=0xDEADBEEF, mem_r_en_out=1, wb_en_out=1.
- Store, alu_res_in=1024+4*63, val_r_m_in=0x12345678, ack after 4 WAIT cycles -> mem_addr=63, mem_we=1, mem_wdata stable throughout, freeze high 5 cycles, then wb_en_out=0 for the store.
- ADD with wb_en_in=1, alu_res_in=7 -> no mem_req, freeze=0, next edge alu_res_out=7, dest_out=dest_in.
- Load at alu_res_in=1000, then at 1024+256 -> no mem_req for either, addr_err=1 and stays 1, mem_data_out=0.
- WAIT with no ack for TIMEOUT=15 cycles -> mem_req drops in cycle 16, addr_err=1, mem_data_out=0, pipeline resumes.
- rst=0 asserted in 2nd WAIT cycle, then late mem_ack -> mem_req and freeze fall without a clock edge, outputs 0, state IDLE, ack ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared widths, memory map and FSM encoding for the MEM stage
package mem_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam int MEM_WORDS  = 64;
  localparam int MEM_ADDR_W = 6;

  localparam logic [DATA_W-1:0] MEM_BASE  = 32'd1024;
  // First byte address past the end of data memory
  localparam logic [DATA_W-1:0] MEM_LIMIT = MEM_BASE + 32'(4 * MEM_WORDS);

  // Last WAIT cycle index; the request is withdrawn when the counter hits it
  localparam logic [3:0] TIMEOUT = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic addr_in_range(input logic [DATA_W-1:0] addr);
    return (addr >= MEM_BASE) && (addr < MEM_LIMIT);
  endfunction

endpackage

// File: rtl/mem_stage_reg.sv
// rtl/mem_stage_reg.sv - MEM/WB pipeline register, loads a bubble while frozen
import mem_stage_pkg::*;

module mem_stage_reg (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_freeze,
  input  logic                  i_wb_en,
  input  logic                  i_mem_r_en,
  input  logic [DATA_W-1:0]     i_alu_res,
  input  logic [DATA_W-1:0]     i_mem_data,
  input  logic [REG_ADDR_W-1:0] i_dest,
  output logic                  o_wb_en,
  output logic                  o_mem_r_en,
  output logic [DATA_W-1:0]     o_alu_res,
  output logic [DATA_W-1:0]     o_mem_data,
  output logic [REG_ADDR_W-1:0] o_dest
);

  // Capture the instruction when running; insert a bubble (controls only) when frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_wb_en    <= 1'b0;
      o_mem_r_en <= 1'b0;
      o_alu_res  <= '0;
      o_mem_data <= '0;
      o_dest     <= '0;
    end else if (i_freeze) begin
      o_wb_en    <= 1'b0;
      o_mem_r_en <= 1'b0;
    end else begin
      o_wb_en    <= i_wb_en;
      o_mem_r_en <= i_mem_r_en;
      o_alu_res  <= i_alu_res;
      o_mem_data <= i_mem_data;
      o_dest     <= i_dest;
    end
  end

endmodule

// File: rtl/mem_stage_module.sv
// rtl/mem_stage_module.sv - MEM stage: address decode, memory handshake FSM, timeout
import mem_stage_pkg::*;

module mem_stage_module (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [DATA_W-1:0]     alu_res_in,
  input  logic [DATA_W-1:0]     val_r_m_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  freeze,
  output logic                  addr_err,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic [REG_ADDR_W-1:0] dest_out
);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic                  r_we;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0]     r_wdata;

  logic                  w_access;
  logic                  w_in_range;
  logic [MEM_ADDR_W-1:0] w_addr;
  logic                  w_freeze;
  logic                  w_req;
  logic                  w_start;
  logic                  w_oor;
  logic                  w_take;
  logic                  w_tmo;
  logic [DATA_W-1:0]     w_mem_data;

  assign w_access   = mem_r_en_in | mem_w_en_in;
  assign w_in_range = addr_in_range(alu_res_in);
  // Byte offset bits drop out of the shift; only the word index is kept
  assign w_addr     = MEM_ADDR_W'((alu_res_in - MEM_BASE) >> 2);

  // Next-state and handshake decode; an ack only counts while the request is up
  always_comb begin
    w_next_state = r_state;
    w_freeze     = 1'b0;
    w_req        = 1'b0;
    w_start      = 1'b0;
    w_oor        = 1'b0;
    w_take       = 1'b0;
    w_tmo        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access) begin
          if (w_in_range) begin
            w_next_state = S_WAIT;
            w_freeze     = 1'b1;
            w_start      = 1'b1;
          end else begin
            w_oor = 1'b1;
          end
        end
      end
      S_WAIT: begin
        w_freeze = 1'b1;
        if (r_cnt == TIMEOUT) begin
          w_tmo        = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_req = 1'b1;
          if (mem_ack) begin
            w_take       = 1'b1;
            w_next_state = S_DONE;
          end
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, timeout counter, captured request fields, read data and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (r_state == S_WAIT) ? r_cnt + 4'd1 : 4'd0;
      if (w_start) begin
        r_we    <= mem_w_en_in;
        r_addr  <= w_addr;
        r_wdata <= val_r_m_in;
        r_rdata <= '0;
      end
      if (w_take) begin
        r_rdata <= mem_rdata;
      end else if (w_tmo) begin
        r_rdata <= '0;
      end
      if (w_oor || w_tmo) begin
        r_err <= 1'b1;
      end
    end
  end

  // Gate with reset so request and freeze fall the moment reset is asserted
  assign mem_req   = w_req & rst;
  assign freeze    = w_freeze & rst;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign addr_err  = r_err;

  assign w_mem_data = (r_state == S_DONE) ? r_rdata : '0;

  mem_stage_reg u_stage_reg (
    .clk        (clk),
    .rst        (rst),
    .i_freeze   (freeze),
    .i_wb_en    (wb_en_in),
    .i_mem_r_en (mem_r_en_in),
    .i_alu_res  (alu_res_in),
    .i_mem_data (w_mem_data),
    .i_dest     (dest_in),
    .o_wb_en    (wb_en_out),
    .o_mem_r_en (mem_r_en_out),
    .o_alu_res  (alu_res_out),
    .o_mem_data (mem_data_out),
    .o_dest     (dest_out)
  );

endmodule

// File: tb/tb_mem_stage_module.sv
// tb/tb_mem_stage_module.sv - directed self-checking bench for mem_stage_module
module tb_mem_stage_module;

  logic        clk;
  logic        rst;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic [31:0] alu_res_in;
  logic [31:0] val_r_m_in;
  logic [3:0]  dest_in;
  logic        mem_req;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        freeze;
  logic        addr_err;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic [31:0] alu_res_out;
  logic [31:0] mem_data_out;
  logic [3:0]  dest_out;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_module dut (
    .clk          (clk),
    .rst          (rst),
    .wb_en_in     (wb_en_in),
    .mem_r_en_in  (mem_r_en_in),
    .mem_w_en_in  (mem_w_en_in),
    .alu_res_in   (alu_res_in),
    .val_r_m_in   (val_r_m_in),
    .dest_in      (dest_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .freeze       (freeze),
    .addr_err     (addr_err),
    .wb_en_out    (wb_en_out),
    .mem_r_en_out (mem_r_en_out),
    .alu_res_out  (alu_res_out),
    .mem_data_out (mem_data_out),
    .dest_out     (dest_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic wb, input logic rd, input logic wr,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dst);
    wb_en_in    = wb;
    mem_r_en_in = rd;
    mem_w_en_in = wr;
    alu_res_in  = alu;
    val_r_m_in  = val;
    dest_in     = dst;
  endtask

  initial begin
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_err", 32'(addr_err), 32'd0);
    chk("rst_wb", 32'(wb_en_out), 32'd0);
    chk("rst_alu", alu_res_out, 32'd0);
    tick();
    rst = 1'b1;

    // Load at 1028, ack on the first WAIT cycle
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd1028, 32'd0, 4'd3);
    #1;
    chk("ld_idle_freeze", 32'(freeze), 32'd1);
    chk("ld_idle_req", 32'(mem_req), 32'd0);
    tick();
    chk("ld_w1_req", 32'(mem_req), 32'd1);
    chk("ld_w1_we", 32'(mem_we), 32'd0);
    chk("ld_w1_addr", 32'(mem_addr), 32'd1);
    chk("ld_w1_freeze", 32'(freeze), 32'd1);
    chk("ld_w1_bubble", 32'(wb_en_out), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    chk("ld_done_freeze", 32'(freeze), 32'd0);
    chk("ld_done_req", 32'(mem_req), 32'd0);
    tick();
    chk("ld_data", mem_data_out, 32'hDEADBEEF);
    chk("ld_ren", 32'(mem_r_en_out), 32'd1);
    chk("ld_wb", 32'(wb_en_out), 32'd1);
    chk("ld_dest", 32'(dest_out), 32'd3);

    // Store at the last word, ack on the fourth WAIT cycle
    drive(1'b0, 1'b0, 1'b1, 32'd1276, 32'h12345678, 4'd5);
    #1;
    chk("st_idle_freeze", 32'(freeze), 32'd1);
    chk("st_idle_req", 32'(mem_req), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("st_wait_req", 32'(mem_req), 32'd1);
      chk("st_wait_we", 32'(mem_we), 32'd1);
      chk("st_wait_addr", 32'(mem_addr), 32'd63);
      chk("st_wait_wdata", mem_wdata, 32'h12345678);
      chk("st_wait_freeze", 32'(freeze), 32'd1);
      if (i == 4) mem_ack = 1'b1;
    end
    tick();
    mem_ack = 1'b0;
    chk("st_done_freeze", 32'(freeze), 32'd0);
    tick();
    chk("st_wb", 32'(wb_en_out), 32'd0);
    chk("st_ren", 32'(mem_r_en_out), 32'd0);
    chk("st_alu", alu_res_out, 32'd1276);
    chk("st_dest", 32'(dest_out), 32'd5);

    // Non-memory instruction passes in one cycle
    drive(1'b1, 1'b0, 1'b0, 32'd7, 32'd0, 4'd9);
    #1;
    chk("add_freeze", 32'(freeze), 32'd0);
    chk("add_req", 32'(mem_req), 32'd0);
    tick();
    chk("add_alu", alu_res_out, 32'd7);
    chk("add_dest", 32'(dest_out), 32'd9);
    chk("add_wb", 32'(wb_en_out), 32'd1);
    chk("add_data", mem_data_out, 32'd0);
    chk("add_err", 32'(addr_err), 32'd0);

    // Load that never gets an ack times out
    drive(1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd4);
    mem_rdata = 32'hAAAAAAAA;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("tmo_req_up", 32'(mem_req), 32'd1);
    end
    tick();
    chk("tmo_req_drop", 32'(mem_req), 32'd0);
    chk("tmo_freeze16", 32'(freeze), 32'd1);
    tick();
    chk("tmo_done_freeze", 32'(freeze), 32'd0);
    chk("tmo_err", 32'(addr_err), 32'd1);
    tick();
    chk("tmo_data", mem_data_out, 32'd0);
    chk("tmo_ren", 32'(mem_r_en_out), 32'd1);
    chk("tmo_dest", 32'(dest_out), 32'd4);
    mem_rdata = 32'h0;

    // Reset clears the sticky error
    rst = 1'b0;
    #1;
    chk("err_clr", 32'(addr_err), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd1000, 32'd0, 4'd2);
    rst = 1'b1;
    #1;

    // Out-of-range loads below and above the window
    chk("oor_lo_freeze", 32'(freeze), 32'd0);
    tick();
    chk("oor_lo_req", 32'(mem_req), 32'd0);
    chk("oor_lo_err", 32'(addr_err), 32'd1);
    chk("oor_lo_data", mem_data_out, 32'd0);
    chk("oor_lo_alu", alu_res_out, 32'd1000);
    drive(1'b1, 1'b1, 1'b0, 32'd1280, 32'd0, 4'd6);
    #1;
    chk("oor_hi_freeze", 32'(freeze), 32'd0);
    tick();
    chk("oor_hi_req", 32'(mem_req), 32'd0);
    chk("oor_hi_err", 32'(addr_err), 32'd1);
    chk("oor_hi_data", mem_data_out, 32'd0);
    chk("oor_hi_alu", alu_res_out, 32'd1280);

    // Reset in the second WAIT cycle, then a late ack
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd8);
    tick();
    tick();
    chk("rw_w2_req", 32'(mem_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rw_req", 32'(mem_req), 32'd0);
    chk("rw_freeze", 32'(freeze), 32'd0);
    chk("rw_wb", 32'(wb_en_out), 32'd0);
    chk("rw_alu", alu_res_out, 32'd0);
    chk("rw_dest", 32'(dest_out), 32'd0);
    chk("rw_err", 32'(addr_err), 32'd0);
    tick();
    mem_ack = 1'b1;
    mem_rdata = 32'h0BADF00D;
    rst = 1'b1;
    #1;
    chk("rw_idle_freeze", 32'(freeze), 32'd1);
    chk("rw_idle_req", 32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("rw_late_ack_ign", 32'(mem_req), 32'd1);
    chk("rw_addr", 32'(mem_addr), 32'd2);
    mem_ack = 1'b1;
    mem_rdata = 32'h00000055;
    tick();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    chk("rw_done_freeze", 32'(freeze), 32'd0);
    tick();
    chk("rw_data", mem_data_out, 32'h00000055);
    chk("rw_wb_out", 32'(wb_en_out), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
